// File: rtl/xalu_pkg.sv
// ----------------------------------------------------------------------------
// xalu_pkg
// Shared definitions for the HI/LO multiply/divide unit.
//   op_e      : XALU opcode presented on the operation bus
//   state_e   : control FSM state encoding
//   DIV_ITERS : number of radix-2 restoring divide iterations
//   CNT_W     : width of the shared multiply/divide cycle counter
//   cond_neg  : two's complement negate when requested (sign handling)
// ----------------------------------------------------------------------------
package xalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    localparam int DIV_ITERS = 32;
    // Covers both the divide iteration count and the multiply latency (<= 8).
    localparam int CNT_W     = 5;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/xalu_ctrl_if.sv
// ----------------------------------------------------------------------------
// xalu_ctrl_if
// Operation / result bus between the issuing pipeline and the XALU.
//   op_valid, op, src_a, src_b, flush : pipeline -> XALU
//   busy, done, hi, lo                : XALU -> pipeline
// Modports: master (pipeline side), slave (XALU side).
// ----------------------------------------------------------------------------
interface xalu_ctrl_if;

    logic            op_valid;
    xalu_pkg::op_e   op;
    logic [31:0]     src_a;
    logic [31:0]     src_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [31:0]     hi;
    logic [31:0]     lo;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/xalu_div_iter.sv
// ----------------------------------------------------------------------------
// xalu_div_iter
// Radix-2 restoring divider datapath on unsigned magnitudes; one quotient bit
// per enabled cycle, so 32 enables produce the full quotient and remainder.
//   clk, resetn         : clock, asynchronous active-low reset
//   i_load              : capture dividend/divisor, clear remainder
//   i_en                : perform one iteration
//   i_dividend/i_divisor: unsigned magnitudes
//   o_quo/o_rem         : quotient and remainder shift registers
// ----------------------------------------------------------------------------
module xalu_div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // The dividend drains out of r_quo MSB-first while quotient bits fill it
    // from the LSB. The remainder is always below the divisor, so the 33-bit
    // subtraction's MSB is a clean borrow flag (also for a zero divisor, which
    // yields quotient all-ones and remainder equal to the dividend).
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_en) begin
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end
    end

    assign o_quo = r_quo;
    assign o_rem = r_rem;

endmodule

// File: rtl/xalu_ctrl.sv
// ----------------------------------------------------------------------------
// xalu_ctrl
// MIPS-style HI/LO unit: multi-cycle MULT/MULTU, 33-cycle DIV/DIVU (32
// restoring iterations plus one sign-fixup cycle), single-cycle MTHI/MTLO.
//   clk     : clock, rising edge
//   resetn  : asynchronous active-low reset
//   xif     : xalu_ctrl_if.slave (op_valid/op/src_a/src_b/flush in,
//             busy/done/hi/lo out)
// Parameter MUL_LAT (1..8): busy cycles for MULT/MULTU.
// Build option: define XALU_DIV_ZERO_SHORTCUT_EN to finish DIV/DIVU by zero
// after a single busy cycle with hi=src_a, lo=0xFFFFFFFF.
// ----------------------------------------------------------------------------
module xalu_ctrl
    import xalu_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    xalu_ctrl_if.slave xif
);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_signed;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_accept;
    logic               w_div_load;
    logic               w_div_en;
    logic               w_wr_hilo;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic [63:0]        w_prod;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic               w_op_signed;
    logic               w_dz;

    assign w_accept    = xif.op_valid && !r_busy && !xif.flush;
    assign w_op_signed = (xif.op == OP_MULT) || (xif.op == OP_DIV);

    // Low 64 bits of the product of sign- (or zero-) extended operands equal
    // the signed (or unsigned) 32x32 product.
    assign w_prod = {{32{r_a[31] & r_signed}}, r_a} * {{32{r_b[31] & r_signed}}, r_b};

    xalu_div_iter u_div (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_div_load),
        .i_en       (w_div_en),
        .i_dividend (cond_neg(xif.src_a, w_op_signed & xif.src_a[31])),
        .i_divisor  (cond_neg(xif.src_b, w_op_signed & xif.src_b[31])),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

`ifdef XALU_DIV_ZERO_SHORTCUT_EN
    logic r_dz;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       r_dz <= 1'b0;
        else if (w_accept) r_dz <= (xif.src_b == '0);
    end
    assign w_dz = r_dz;
`else
    assign w_dz = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_div_load = 1'b0;
        w_div_en   = 1'b0;
        w_wr_hilo  = 1'b0;
        w_wr_hi    = 1'b0;
        w_wr_lo    = 1'b0;
        w_res_hi   = '0;
        w_res_lo   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (xif.op)
                        OP_MULT, OP_MULTU: begin
                            w_next     = ST_MUL;
                            w_cnt_next = '0;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_div_load = 1'b1;
                            w_cnt_next = '0;
`ifdef XALU_DIV_ZERO_SHORTCUT_EN
                            w_next     = (xif.src_b == '0) ? ST_FIX : ST_DIV;
`else
                            w_next     = ST_DIV;
`endif
                        end
                        OP_MTHI: w_wr_hi = 1'b1;
                        OP_MTLO: w_wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
                    w_next    = ST_IDLE;
                    w_wr_hilo = 1'b1;
                    w_res_hi  = w_prod[63:32];
                    w_res_lo  = w_prod[31:0];
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DIV: begin
                w_div_en = 1'b1;
                if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
                    w_next     = ST_FIX;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_FIX: begin
                w_next    = ST_IDLE;
                w_wr_hilo = 1'b1;
                if (w_dz) begin
                    w_res_hi = r_a;
                    w_res_lo = '1;
                end else begin
                    // Quotient sign = sign(a) ^ sign(b); remainder follows a.
                    w_res_lo = cond_neg(w_quo, r_signed & (r_a[31] ^ r_b[31]));
                    w_res_hi = cond_neg(w_rem, r_signed & r_a[31]);
                end
            end
            default: w_next = ST_IDLE;
        endcase

        // Flush wins over everything, including the completing cycle.
        if (r_state != ST_IDLE && xif.flush) begin
            w_next     = ST_IDLE;
            w_cnt_next = '0;
            w_div_en   = 1'b0;
            w_wr_hilo  = 1'b0;
        end
    end

    // NOTE: every register, including operand latches, takes a defined reset
    // value so nothing reaches the outputs as X after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_busy <= (w_next != ST_IDLE);
            r_done <= w_wr_hilo;
            if (w_accept) begin
                r_a      <= xif.src_a;
                r_b      <= xif.src_b;
                r_signed <= w_op_signed;
            end
            if (w_wr_hilo) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
            if (w_wr_hi) r_hi <= xif.src_a;
            if (w_wr_lo) r_lo <= xif.src_a;
        end
    end

    assign xif.busy = r_busy;
    assign xif.done = r_done;
    assign xif.hi   = r_hi;
    assign xif.lo   = r_lo;

endmodule

// File: tb/tb_xalu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_xalu_ctrl
// Directed bench for xalu_ctrl: expected HI/LO values come from a behavioural
// model and are queued at issue, then popped when done pulses.
// ----------------------------------------------------------------------------
module tb_xalu_ctrl;
    import xalu_pkg::*;

    localparam int MUL_LAT  = 4;
    localparam int DIV_BUSY = DIV_ITERS + 1;
`ifdef XALU_DIV_ZERO_SHORTCUT_EN
    localparam int DZ_BUSY  = 1;
`else
    localparam int DZ_BUSY  = DIV_BUSY;
`endif

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk = 1'b0;
    logic        resetn;
    res_t        sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    xalu_ctrl_if xif ();

    xalu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .xif    (xif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input op_e o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_, q, r;
        logic [63:0] p;
        res_t        res;
        sa = $signed(a);
        sb_ = $signed(b);
        res = '0;
        case (o)
            OP_MULT:  begin p = sa * sb_; res = {p[63:32], p[31:0]}; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; res = {p[63:32], p[31:0]}; end
            OP_DIV: begin
                if (b == '0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    p = q;
                    res.lo = p[31:0];
                    p = r;
                    res.hi = p[31:0];
                end
            end
            OP_DIVU: begin
                if (b == '0) res = {a, 32'hFFFF_FFFF};
                else         res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        xif.op_valid = 1'b0;
        xif.op       = OP_NOP;
        xif.flush    = 1'b0;
    endtask

    // Presents one op for one cycle while idle; returns at cycle 1 after accept.
    task automatic issue(input string tag, input op_e o, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        xif.op_valid = 1'b1;
        xif.op       = o;
        xif.src_a    = a;
        xif.src_b    = b;
        step();
        idle_bus();
        xif.src_a = ~a;
        xif.src_b = ~b;
        if (o == OP_MTHI || o == OP_MTLO) begin
            if (o == OP_MTHI) exp_hi = a;
            else              exp_lo = a;
            check({tag, "_hi"},   xif.hi,   exp_hi);
            check({tag, "_lo"},   xif.lo,   exp_lo);
            check({tag, "_busy"}, 32'(xif.busy), 32'd0);
            check({tag, "_done"}, 32'(xif.done), 32'd0);
        end else begin
            if (push) sb.push_back(model(o, a, b));
            check({tag, "_busy1"}, 32'(xif.busy), 32'd1);
            check({tag, "_done1"}, 32'(xif.done), 32'd0);
        end
    endtask

    // Counts busy cycles while hammering the bus with ignored MTLO ops and
    // changing operands; returns in the done cycle.
    task automatic wait_done(input string tag, input int exp_busy);
        int   n;
        res_t e;
        n = 1;
        while (xif.busy === 1'b1 && n < 100) begin
            xif.op_valid = 1'b1;
            xif.op       = OP_MTLO;
            xif.src_a    = $urandom;
            xif.src_b    = $urandom;
            step();
            if (xif.busy === 1'b1) n++;
        end
        idle_bus();
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        check({tag, "_done"}, 32'(xif.done), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            exp_hi = e.hi;
            exp_lo = e.lo;
            check({tag, "_hi"}, xif.hi, exp_hi);
            check({tag, "_lo"}, xif.lo, exp_lo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        idle_bus();
        xif.src_a = '0;
        xif.src_b = '0;
        step();
        check("rst_busy", 32'(xif.busy), 32'd0);
        check("rst_done", 32'(xif.done), 32'd0);
        check("rst_hi",   xif.hi, 32'd0);
        check("rst_lo",   xif.lo, 32'd0);
        resetn = 1'b1;
        step();

        issue("mthi", OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
        issue("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0);

        // MULT -2 * 3; MTLO noise during busy must be ignored.
        issue("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_done("mult_neg", MUL_LAT);
        check("mult_neg_hi_const", exp_hi, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", exp_lo, 32'hFFFF_FFFA);

        // Back-to-back: accept in the done cycle.
        issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu_max", MUL_LAT);
        issue("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("mult_min", MUL_LAT);
        step();
        check("done_one_pulse", 32'(xif.done), 32'd0);

        issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div_m7_2", DIV_BUSY);
        check("div_m7_2_lo_const", exp_lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi_const", exp_hi, 32'hFFFF_FFFF);
        issue("divu_7_2", OP_DIVU, 32'd7, 32'd2, 1'b1);
        wait_done("divu_7_2", DIV_BUSY);
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_ovf", DIV_BUSY);
        check("div_ovf_lo_const", exp_lo, 32'h8000_0000);
        issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("div_7_m2", DIV_BUSY);
        issue("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'h0001_0003, 1'b1);
        wait_done("divu_big", DIV_BUSY);
        issue("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1'b1);
        wait_done("divu_5_0", DZ_BUSY);
        step();

        // Flush at cycle 10 of a DIVU: no write, no done.
        issue("flush_div", OP_DIVU, 32'd100, 32'd3, 1'b0);
        repeat (9) step();
        xif.flush = 1'b1;
        step();
        xif.flush = 1'b0;
        check("flush_div_busy", 32'(xif.busy), 32'd0);
        check("flush_div_done", 32'(xif.done), 32'd0);
        check("flush_div_hi",   xif.hi, exp_hi);
        check("flush_div_lo",   xif.lo, exp_lo);
        step();
        check("flush_div_done2", 32'(xif.done), 32'd0);

        // Flush in the completing MUL cycle suppresses write and pulse.
        issue("flush_mul", OP_MULT, 32'd9, 32'd9, 1'b0);
        repeat (MUL_LAT - 1) step();
        xif.flush = 1'b1;
        step();
        xif.flush = 1'b0;
        check("flush_mul_busy", 32'(xif.busy), 32'd0);
        check("flush_mul_done", 32'(xif.done), 32'd0);
        check("flush_mul_hi",   xif.hi, exp_hi);
        check("flush_mul_lo",   xif.lo, exp_lo);

        // Flush blocks acceptance while idle.
        xif.op_valid = 1'b1;
        xif.op       = OP_MTHI;
        xif.src_a    = 32'hDEAD_BEEF;
        xif.flush    = 1'b1;
        step();
        idle_bus();
        check("flush_idle_hi", xif.hi, exp_hi);

        // Asynchronous reset mid-MULT, then a clean MULT.
        issue("rst_mul", OP_MULT, 32'd11, 32'd13, 1'b0);
        step();
        resetn = 1'b0;
        #1;
        check("async_rst_busy", 32'(xif.busy), 32'd0);
        check("async_rst_done", 32'(xif.done), 32'd0);
        check("async_rst_hi",   xif.hi, 32'd0);
        check("async_rst_lo",   xif.lo, 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        step();
        resetn = 1'b1;
        step();
        issue("post_rst", OP_MULT, 32'd6, 32'd7, 1'b1);
        wait_done("post_rst", MUL_LAT);
        check("post_rst_lo_const", exp_lo, 32'd42);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/xalu_ctrl.md
XALU_CTRL -- requirements
Module: xalu_ctrl

Interface
REQ-001 SHALL provide parameter MUL_LAT, default 4, meaning the number of busy cycles for MULT/MULTU (legal range 1..8).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port op_valid, input, 1, an XALU operation is presented this cycle.
REQ-005 SHALL have port op, input, 3, opcode from package enum: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have ports src_a and src_b, input, 32 each, Rs and Rt operand values.
REQ-007 SHALL have port flush, input, 1, exception flush that kills the in-flight operation.
REQ-008 SHALL have port busy, output, 1, registered, high while a MULT/DIV operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse in the cycle the new HI/LO values first become visible.
REQ-010 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers that feed MFHI/MFLO.

Function
REQ-011 SHALL accept an operation only when op_valid=1, busy=0 and flush=0; otherwise SHALL ignore op.
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX; busy SHALL be 1 in every state except IDLE.
REQ-013 MTHI and MTLO SHALL write src_a to hi or lo on the accept edge; busy SHALL stay 0 and done SHALL stay 0.
REQ-014 MULT and MULTU SHALL go IDLE->MUL; busy SHALL be 1 for exactly MUL_LAT cycles starting the cycle after accept.
REQ-015 On the MUL->IDLE edge, {hi,lo} SHALL be written with the 64-bit signed (MULT) or unsigned (MULTU) product, and done SHALL pulse.
REQ-016 DIV and DIVU SHALL go IDLE->DIV, run 32 radix-2 restoring iterations on magnitudes, then one FIX cycle for sign correction; busy SHALL last 33 cycles.
REQ-017 The division result SHALL be lo = quotient and hi = remainder.
REQ-018 For signed divide, the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL equal sign(a).
REQ-019 For 0x80000000 / 0xFFFFFFFF (signed), the result SHALL be lo=0x80000000 and hi=0.
REQ-020 flush=1 while busy SHALL return the FSM to IDLE on the next edge; hi/lo SHALL be unchanged and done SHALL not pulse.
REQ-021 flush=1 in the cycle done would pulse SHALL suppress the write and the pulse; flush has priority over completion.
REQ-022 Operands SHALL be latched on accept; later src_a/src_b changes SHALL have no effect on the result.
REQ-023 A new operation SHALL be accepted no earlier than the cycle after busy falls (the done cycle has busy=0, so it may accept).

Reset
REQ-024 While resetn=0: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
REQ-025 Reset asserted mid-operation SHALL abort it immediately and asynchronously, with no HI/LO write.

Configuration
REQ-026 Macro XALU_DIV_ZERO_SHORTCUT_EN defined: DIV/DIVU with src_b=0 SHALL finish after 1 busy cycle with hi=src_a, lo=0xFFFFFFFF, done pulsing.
REQ-027 Macro undefined: divide-by-zero SHALL take the full 33 cycles and write the deterministic restoring-algorithm result.

Structure
REQ-028 The op enum, the FSM state encoding and the DIV_ITERS=32 constant SHALL live in the shared xalu package.
REQ-029 One sub-module, xalu_div_iter, SHALL hold the remainder/quotient shift registers and do one iteration per enable; xalu_ctrl owns FSM, counter, sign fixup, multiplier and HI/LO.

Verification
REQ-030 MULT a=0xFFFFFFFE (-2), b=3, MUL_LAT=4 -> busy high cycles 1..4 after accept; done at cycle 5; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 DIV a=-7 (0xFFFFFFF9), b=2 -> 33 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
REQ-032 MTHI 0x12345678 while idle -> hi=0x12345678 next cycle, busy=0, done=0. MTLO presented while busy -> ignored.
REQ-033 DIVU started, flush at cycle 10 -> IDLE next cycle, busy=0, hi/lo retain prior values, no done.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 with macro -> 1 busy cycle, hi=5, lo=0xFFFFFFFF.
REQ-035 resetn pulsed low mid-MULT -> busy=0 and hi=lo=0 asynchronously; a MULT issued after release completes normally.
